// File: rtl/exec_control_fsm.sv
// ---------------------------------------------------------------------------
// exec_control_fsm -- execute-stage controller for the VanilaCore pipeline.
//
// Decodes the instruction presented on decode_bus when execute is high and
// the controller is idle. It drives the datapath selects, register-file and
// CSR write strobes, jump/branch enables, the load/store bus handshake and
// precise trap reporting. A bus access that does not complete within
// MEM_TIMEOUT cycles raises an access-fault trap.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   execute           decoded instruction valid (sampled only in IDLE)
//   decode_bus        opcode / funct3 / rs1 / i_imm
//   busy              multi-cycle (memory) instruction in progress
//   sr2_src           ALU operand-2 select
//   regfile_src       write-back select
//   jmp_target_src    jump target select
//   regfile_wr        register-file write strobe
//   jump              JAL/JALR strobe
//   enable_branch     BRANCH strobe
//   imm_t             OP_IMM flag
//   memory_operation  current bus operation
//   cyc, ack          bus request / bus accepted
//   data_valid        load data present
//   csr_op, csr_wr    CSR operation (funct3) and CSR write strobe
//   trap, trap_cause  trap strobe and mcause code
// ---------------------------------------------------------------------------
package global_pkg;

    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] SYSTEM = 7'b1110011;

    typedef struct packed {
        logic [6:0]  opcode;
        logic [2:0]  funct3;
        logic [4:0]  rs1;
        logic [11:0] i_imm;
    } decode;

    typedef enum logic {I_IMM_SRC, REG_SRC} sr2_src_t;

    typedef enum logic [2:0] {
        ALU_INPUT, U_IMM_SRC, AUIPC_SRC, PC_SRC, LOAD_SRC, CSR_SRC
    } regfile_src_t;

    typedef enum logic [1:0] {J_IMM, I_IMM, B_IMM} jmp_target_src_t;

    typedef enum logic [1:0] {MEM_NONE, LOAD_DATA, STORE_DATA} memory_operation_t;

endpackage

// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | accepts execute; single-cycle instructions complete here
// MEM_REQ  | cyc held high, waiting for ack (load or store)
// MEM_WAIT | load accepted, waiting for data_valid
module exec_control_fsm
    import global_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 255,
    parameter int unsigned TIMEOUT_W   = $clog2(MEM_TIMEOUT + 1),
    parameter bit          ENABLE_CSR  = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              execute,
    input  decode             decode_bus,
    output logic              busy,
    output sr2_src_t          sr2_src,
    output regfile_src_t      regfile_src,
    output jmp_target_src_t   jmp_target_src,
    output logic              regfile_wr,
    output logic              jump,
    output logic              enable_branch,
    output logic              imm_t,
    output memory_operation_t memory_operation,
    output logic              cyc,
    input  logic              ack,
    input  logic              data_valid,
    output logic [2:0]        csr_op,
    output logic              csr_wr,
    output logic              trap,
    output logic [3:0]        trap_cause
);

    typedef enum logic [1:0] {IDLE, MEM_REQ, MEM_WAIT} state_t;

    // A zero-width counter is not legal, so MEM_TIMEOUT=0 keeps one dummy bit.
    localparam int CNT_W = (TIMEOUT_W == 0) ? 1 : int'(TIMEOUT_W);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MEM_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = (MEM_TIMEOUT == 0) ? '0 : CNT_W'(MEM_TIMEOUT - 1);

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             timeout_hit;

    // The counter saturates so a load whose ack lands on the last allowed
    // cycle still times out in MEM_WAIT instead of wrapping.
    assign cnt_d       = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
    // True on the edge that would complete the MEM_TIMEOUT-th counted cycle.
    assign timeout_hit = (MEM_TIMEOUT != 0) && (cnt_q >= CNT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= IDLE;
            cnt_q            <= '0;
            busy             <= 1'b0;
            cyc              <= 1'b0;
            memory_operation <= MEM_NONE;
            sr2_src          <= I_IMM_SRC;
            regfile_src      <= ALU_INPUT;
            jmp_target_src   <= J_IMM;
            imm_t            <= 1'b0;
            csr_op           <= 3'd0;
            regfile_wr       <= 1'b0;
            jump             <= 1'b0;
            enable_branch    <= 1'b0;
            csr_wr           <= 1'b0;
            trap             <= 1'b0;
            trap_cause       <= 4'd0;
        end else begin
            regfile_wr    <= 1'b0;
            jump          <= 1'b0;
            enable_branch <= 1'b0;
            csr_wr        <= 1'b0;
            trap          <= 1'b0;
            trap_cause    <= 4'd0;

            case (state_q)
                IDLE: begin
                    cnt_q            <= '0;
                    busy             <= 1'b0;
                    cyc              <= 1'b0;
                    memory_operation <= MEM_NONE;
                    sr2_src          <= I_IMM_SRC;
                    regfile_src      <= ALU_INPUT;
                    jmp_target_src   <= J_IMM;
                    imm_t            <= 1'b0;
                    csr_op           <= 3'd0;
                    if (execute) begin
                        case (decode_bus.opcode)
                            OP_IMM: begin
                                imm_t      <= 1'b1;
                                regfile_wr <= 1'b1;
                            end
                            OP: begin
                                sr2_src    <= REG_SRC;
                                regfile_wr <= 1'b1;
                            end
                            LUI: begin
                                regfile_src <= U_IMM_SRC;
                                regfile_wr  <= 1'b1;
                            end
                            AUIPC: begin
                                regfile_src <= AUIPC_SRC;
                                regfile_wr  <= 1'b1;
                            end
                            JAL: begin
                                regfile_src <= PC_SRC;
                                jump        <= 1'b1;
                                regfile_wr  <= 1'b1;
                            end
                            JALR: begin
                                regfile_src    <= PC_SRC;
                                jmp_target_src <= I_IMM;
                                jump           <= 1'b1;
                                regfile_wr     <= 1'b1;
                            end
                            BRANCH: begin
                                jmp_target_src <= B_IMM;
                                enable_branch  <= 1'b1;
                            end
                            SYSTEM: begin
                                if (decode_bus.funct3 == 3'b000) begin
                                    trap <= 1'b1;
                                    if (decode_bus.i_imm == 12'd0)      trap_cause <= 4'd11;
                                    else if (decode_bus.i_imm == 12'd1) trap_cause <= 4'd3;
                                    else                                trap_cause <= 4'd2;
                                end else if (decode_bus.funct3 == 3'b100 || !ENABLE_CSR) begin
                                    trap       <= 1'b1;
                                    trap_cause <= 4'd2;
                                end else begin
                                    csr_op      <= decode_bus.funct3;
                                    regfile_src <= CSR_SRC;
                                    regfile_wr  <= 1'b1;
                                    // funct3[1] marks the set/clear forms; rs1=0 makes them read-only.
                                    csr_wr      <= !(decode_bus.funct3[1] && (decode_bus.rs1 == 5'd0));
                                end
                            end
                            LOAD: begin
                                memory_operation <= LOAD_DATA;
                                regfile_src      <= LOAD_SRC;
                                busy             <= 1'b1;
                                cyc              <= 1'b1;
                                state_q          <= MEM_REQ;
                            end
                            STORE: begin
                                memory_operation <= STORE_DATA;
                                busy             <= 1'b1;
                                cyc              <= 1'b1;
                                state_q          <= MEM_REQ;
                            end
                            default: begin
                                trap       <= 1'b1;
                                trap_cause <= 4'd2;
                            end
                        endcase
                    end
                end

                MEM_REQ: begin
                    cnt_q <= cnt_d;
                    if (ack) begin
                        cyc <= 1'b0;
                        if (memory_operation == STORE_DATA) begin
                            busy             <= 1'b0;
                            memory_operation <= MEM_NONE;
                            state_q          <= IDLE;
                        end else begin
                            state_q <= MEM_WAIT;
                        end
                    end else if (timeout_hit) begin
                        cyc              <= 1'b0;
                        busy             <= 1'b0;
                        trap             <= 1'b1;
                        trap_cause       <= (memory_operation == STORE_DATA) ? 4'd7 : 4'd5;
                        memory_operation <= MEM_NONE;
                        regfile_src      <= ALU_INPUT;
                        state_q          <= IDLE;
                    end
                end

                MEM_WAIT: begin
                    cnt_q <= cnt_d;
                    if (data_valid) begin
                        regfile_wr       <= 1'b1;
                        busy             <= 1'b0;
                        memory_operation <= MEM_NONE;
                        state_q          <= IDLE;
                    end else if (timeout_hit) begin
                        busy             <= 1'b0;
                        trap             <= 1'b1;
                        trap_cause       <= 4'd5;
                        memory_operation <= MEM_NONE;
                        regfile_src      <= ALU_INPUT;
                        state_q          <= IDLE;
                    end
                end

                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/exec_control_fsm.md
# exec_control_fsm

Parametrised second-generation execute-stage controller for the VanilaCore pipeline. It takes the decoded instruction from `decode_bus` and drives the datapath multiplexers, register-file write, branch/jump enables and load/store handshake. Compared with the first-generation controller it adds:

- a configurable memory-bus timeout with access-fault traps;
- CSR instruction control;
- precise trap reporting for ECALL, EBREAK and illegal opcodes.

All state is posedge-clocked.

## Interface
Parameters:
- `MEM_TIMEOUT`, 255: cycles allowed from `cyc` assertion to completion; 0 disables the timeout.
- `TIMEOUT_W`, `$clog2(MEM_TIMEOUT+1)`: timeout counter width; derived, never overridden.
- `ENABLE_CSR`, 1: 0 makes every SYSTEM funct3≠000 instruction an illegal-instruction trap.

Ports:
- `clk`  in  1  single clock, posedge.
- `rst`  in  1  synchronous reset, active-high.
- `execute`  in  1  decoded instruction valid; sampled only in IDLE.
- `decode_bus`  in  `decode`  opcode, funct3, rs1, i_imm fields.
- `busy`  out  1  instruction in progress; `execute` is ignored while high.
- `sr2_src`  out  `sr2_src_t`  ALU operand-2 select.
- `regfile_src`  out  `regfile_src_t`  write-back select; CSR_SRC is added to global_pkg.
- `jmp_target_src`  out  `jmp_target_src_t`  J_IMM / I_IMM / B_IMM.
- `regfile_wr`  out  1  one-cycle write strobe.
- `jump`  out  1  JAL/JALR strobe.
- `enable_branch`  out  1  BRANCH strobe.
- `imm_t`  out  1  OP_IMM flag.
- `memory_operation`  out  `memory_operation_t`  MEM_NONE / LOAD_DATA / STORE_DATA.
- `cyc`  out  1  bus request.
- `ack`  in  1  bus accepted request.
- `data_valid`  in  1  load data present.
- `csr_op`  out  3  funct3 of the active CSR instruction.
- `csr_wr`  out  1  one-cycle CSR write strobe.
- `trap`  out  1  one-cycle trap strobe.
- `trap_cause`  out  4  mcause code, valid while `trap`=1.

## Operation
States: IDLE, MEM_REQ, MEM_WAIT.

**IDLE, `execute`=1**, decoding `decode_bus.opcode`:
- OP_IMM: sr2_src=I_IMM_SRC, regfile_src=ALU_INPUT, imm_t=1, regfile_wr=1.
- OP: sr2_src=REG_SRC, regfile_src=ALU_INPUT, imm_t=0, regfile_wr=1.
- LUI: regfile_src=U_IMM_SRC, regfile_wr=1.
- AUIPC: regfile_src=AUIPC_SRC, regfile_wr=1.
- JAL: regfile_src=PC_SRC, jmp_target_src=J_IMM, jump=1, regfile_wr=1.
- JALR: regfile_src=PC_SRC, jmp_target_src=I_IMM, jump=1, regfile_wr=1.
- BRANCH: jmp_target_src=B_IMM, enable_branch=1, regfile_wr=0.
- SYSTEM funct3=000: i_imm=0 → trap, cause 11; i_imm=1 → trap, cause 3; any other i_imm → trap, cause 2.
- SYSTEM funct3 ∈ {001,010,011,101,110,111} with ENABLE_CSR=1: csr_op=funct3, regfile_src=CSR_SRC, regfile_wr=1.
  - csr_wr=1 except for CSRRS/CSRRC/CSRRSI/CSRRCI whose rs1 field is 0; those give csr_wr=0.
- SYSTEM funct3=100: trap, cause 2.
- LOAD: memory_operation=LOAD_DATA, regfile_src=LOAD_SRC, busy=1, cyc=1 → MEM_REQ.
- STORE: memory_operation=STORE_DATA, busy=1, cyc=1 → MEM_REQ.
- Any other opcode: trap, cause 2; no write.

**MEM_REQ**
- `cyc` stays high until `ack` is sampled.
- On `ack`, STORE: cyc=0, busy=0, → IDLE.
- On `ack`, LOAD: cyc=0, → MEM_WAIT.

**MEM_WAIT**
- On `data_valid`: regfile_wr=1 for one cycle, busy=0, memory_operation=MEM_NONE, → IDLE.

**Timeout**
- The counter clears on entry to MEM_REQ and increments each cycle spent in MEM_REQ or MEM_WAIT.
- When it reaches MEM_TIMEOUT without completion: cyc=0, busy=0, regfile_wr=0, trap=1, cause 5 for a load or 7 for a store, → IDLE.
- If `ack`/`data_valid` arrives in the same cycle the count reaches MEM_TIMEOUT, completion wins and no trap is raised.

**Strobes and defaults**
- Strobes (regfile_wr, jump, enable_branch, csr_wr, trap) are high for exactly one cycle per instruction.
- IDLE with `execute`=0 drives the idle defaults: all strobes 0, cyc=0, busy=0, memory_operation=MEM_NONE, sr2_src=I_IMM_SRC, regfile_src=ALU_INPUT, jmp_target_src=J_IMM, imm_t=0, csr_op=0, trap_cause=0.
- `ack` or `data_valid` seen while in IDLE is ignored.

## Timing
- All outputs are registered. The reset value of every output is its idle default, and the state resets to IDLE.
- A reset in mid-operation drops `cyc` and `busy` at that same clock edge, and no write or trap is issued.
- Non-memory instructions: `execute` sampled at edge N → controls valid during cycle N+1 for one cycle; `busy` stays 0. Back-to-back `execute` is accepted every cycle.
- Store: `execute` at N → cyc=1 from N+1; `ack` sampled at edge M → cyc=0 and busy=0 from M+1. Next `execute` is accepted at edge M+1.
- Load: `ack` at M → cyc=0 from M+1; `data_valid` sampled at edge D → regfile_wr=1 during D+1 and busy=0 from D+1.
- Minimum latencies: store 2 cycles, load 3 cycles.
- Timeout trap: asserted in the cycle after MEM_TIMEOUT counted cycles.

## Test plan
- **Reset:** `rst`=1 for 2 cycles mid-load with cyc=1 → cyc=0, busy=0, all strobes 0 at the next edge; state IDLE.
- **OP_IMM then JAL, back-to-back:** regfile_wr=1 with imm_t=1 in cycle N+1; jump=1 with regfile_src=PC_SRC and regfile_wr=1 in cycle N+2; busy never rises.
- **Load:** `ack` 3 cycles after `execute`, `data_valid` 2 cycles later → cyc high for 3 cycles; exactly one regfile_wr pulse with regfile_src=LOAD_SRC; busy high for 5 cycles total.
- **Store timeout:** MEM_TIMEOUT=4, `ack` never asserted → cyc high for 4 cycles, then trap=1 with cause 7, busy=0, no regfile_wr. With `ack` on the 4th cycle instead → normal completion, no trap.
- **System traps:** EBREAK (i_imm=1) → trap with cause 3; ECALL → cause 11; opcode 7'b1111111 → cause 2; each trap is a single-cycle pulse with regfile_wr=0.
- **CSR:**
  - CSRRS with rs1=0 → regfile_wr=1, csr_wr=0, csr_op=3'b010.
  - CSRRW with rs1=5 → csr_wr=1.
  - With ENABLE_CSR=0, CSRRW → trap with cause 2.
